// File: rtl/reg_xfer_master_pkg.sv
// reg_xfer_master_pkg: micro-op codes and sequencer state encodings
package reg_xfer_master_pkg;
  localparam logic [1:0] OP_MOV = 2'b00, OP_LDI = 2'b01, OP_SWP = 2'b10, OP_CLR = 2'b11;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RD_Y = 3'd1, S_RD_X = 3'd2, S_WR_X = 3'd3, S_WR_Y = 3'd4, S_DONE = 3'd5
  } state_t;
endpackage

// File: rtl/reg_xfer_master.sv
// reg_xfer_master: sequences MOV/LDI/SWP/CLR micro-ops as register_bank read/write cycles
module reg_xfer_master
  import reg_xfer_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [1:0]            op_code,
  input  logic [SEL_WIDTH-1:0]  op_rx,
  input  logic [SEL_WIDTH-1:0]  op_ry,
  input  logic [DATA_WIDTH-1:0] op_imm,
  output logic                  busy,
  output logic                  done,
  output logic                  reg_read_en,
  output logic                  reg_write_en,
  output logic [SEL_WIDTH-1:0]  reg_rx_sel,
  output logic [SEL_WIDTH-1:0]  reg_ry_sel,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] bus_data
);
  state_t                state;
  logic [1:0]            op;
  logic [SEL_WIDTH-1:0]  rx, ry;
  logic [DATA_WIDTH-1:0] tmp_a, tmp_b;
  assign op_ready = state == S_IDLE;
  // strobes are set on the edge entering each state so every bank-side output is registered
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= S_IDLE;
      op           <= '0;
      rx           <= '0;
      ry           <= '0;
      tmp_a        <= '0;
      tmp_b        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      reg_read_en  <= 1'b0;
      reg_write_en <= 1'b0;
      reg_rx_sel   <= '0;
      reg_ry_sel   <= '0;
      reg_wdata    <= '0;
    end else begin
      reg_read_en  <= 1'b0;
      reg_write_en <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE: if (op_valid) begin
          op   <= op_code;
          rx   <= op_rx;
          ry   <= op_ry;
          busy <= 1'b1;
          if (op_code == OP_MOV || op_code == OP_SWP) begin
            state       <= S_RD_Y;
            reg_read_en <= 1'b1;
            reg_ry_sel  <= op_ry;
          end else begin
            state        <= S_WR_X;
            reg_write_en <= 1'b1;
            reg_rx_sel   <= op_rx;
            reg_wdata    <= op_code == OP_LDI ? op_imm : '0;
          end
        end
        S_RD_Y: begin
          tmp_a <= bus_data;
          if (op == OP_SWP) begin
            state       <= S_RD_X;
            reg_read_en <= 1'b1;
            reg_ry_sel  <= rx;
          end else begin
            state        <= S_WR_X;
            reg_write_en <= 1'b1;
            reg_rx_sel   <= rx;
            reg_wdata    <= bus_data;
          end
        end
        S_RD_X: begin
          tmp_b        <= bus_data;
          state        <= S_WR_X;
          reg_write_en <= 1'b1;
          reg_rx_sel   <= rx;
          reg_wdata    <= tmp_a;
        end
        S_WR_X: if (op == OP_SWP) begin
          state        <= S_WR_Y;
          reg_write_en <= 1'b1;
          reg_rx_sel   <= ry;
          reg_wdata    <= tmp_b;
        end else begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_WR_Y: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_reg_xfer_master.sv
// tb_reg_xfer_master: scoreboard bench with a register-file model and a behavioural bank
module tb_reg_xfer_master;
  localparam logic [1:0] MOV = 2'b00, LDI = 2'b01, SWP = 2'b10, CLR = 2'b11;
  logic       clk = 0, rst_n = 0;
  logic       op_valid = 0, op_ready, busy, done;
  logic [1:0] op_code = 0;
  logic [2:0] op_rx = 0, op_ry = 0, reg_rx_sel, reg_ry_sel;
  logic [7:0] op_imm = 0, reg_wdata, bus_data;
  logic       reg_read_en, reg_write_en;
  logic [7:0] bank [8];
  logic [7:0] model [8];
  typedef struct {int lat; int nrd; int nwr; logic [15:0] rdv; logic [63:0] regs;} exp_t;
  exp_t q[$];
  int passed = 0, total = 0, cyc = 0, acc = 0, last_done = 0;
  bit b2b = 0;
  reg_xfer_master #(.DATA_WIDTH(8), .SEL_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_rx(op_rx), .op_ry(op_ry), .op_imm(op_imm), .busy(busy), .done(done),
    .reg_read_en(reg_read_en), .reg_write_en(reg_write_en), .reg_rx_sel(reg_rx_sel),
    .reg_ry_sel(reg_ry_sel), .reg_wdata(reg_wdata), .bus_data(bus_data)
  );
  always #5 clk = ~clk;
  assign bus_data = bank[reg_ry_sel];
  always @(posedge clk) if (reg_write_en) bank[reg_rx_sel] <= reg_wdata;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask
  function automatic logic [63:0] snap_model();
    logic [63:0] s;
    for (int i = 0; i < 8; i++) s[i*8 +: 8] = model[i];
    return s;
  endfunction
  function automatic logic [63:0] snap_bank();
    logic [63:0] s;
    for (int i = 0; i < 8; i++) s[i*8 +: 8] = bank[i];
    return s;
  endfunction
  initial forever begin
    @(posedge clk);
    if (op_valid && op_ready) begin
      if (b2b) chk("b2b_accept_gap", 64'(cyc - last_done), 64'd1);
      acc = cyc;
    end
    cyc++;
  end
  initial begin
    int nrd = 0, nwr = 0, nbusy = 0;
    logic [15:0] rdv = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nrd = 0; nwr = 0; nbusy = 0; rdv = 0;
      end else begin
        if (reg_read_en && reg_write_en) chk("strobe_overlap", 64'd1, 64'd0);
        if (reg_read_en) begin nrd++; rdv = {rdv[7:0], bus_data}; end
        if (reg_write_en) nwr++;
        if (busy) nbusy++;
        if (done) begin
          last_done = cyc;
          if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            chk("latency", 64'(cyc - acc), 64'(e.lat));
            chk("busy_cycles", 64'(nbusy), 64'(e.lat - 1));
            chk("reads", 64'(nrd), 64'(e.nrd));
            chk("writes", 64'(nwr), 64'(e.nwr));
            chk("read_bus", 64'(rdv), 64'(e.rdv));
            chk("regfile", snap_bank(), e.regs);
          end
          nrd = 0; nwr = 0; nbusy = 0; rdv = 0;
        end
      end
    end
  end
  task automatic issue(input logic [1:0] c, input logic [2:0] x, input logic [2:0] y,
                       input logic [7:0] im, input bit push, input bit hold);
    int n = 0;
    exp_t e;
    @(negedge clk);
    op_valid = 1;
    while (!op_ready && n < 50) begin
      op_code = 2'($urandom); op_rx = 3'($urandom); op_ry = 3'($urandom); op_imm = 8'($urandom);
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("accept_timeout", 64'd1, 64'd0);
    op_code = c; op_rx = x; op_ry = y; op_imm = im;
    @(posedge clk);
    if (push) begin
      e.lat = c == SWP ? 5 : c == MOV ? 3 : 2;
      e.nrd = c == SWP ? 2 : c == MOV ? 1 : 0;
      e.nwr = c == SWP ? 2 : 1;
      e.rdv = c == SWP ? {model[y], model[x]} : c == MOV ? {8'h00, model[y]} : 16'h0;
      case (c)
        MOV: model[x] = model[y];
        LDI: model[x] = im;
        SWP: begin logic [7:0] t; t = model[x]; model[x] = model[y]; model[y] = t; end
        default: model[x] = 8'h00;
      endcase
      e.regs = snap_model();
      q.push_back(e);
    end
    @(negedge clk);
    op_valid = hold;
    op_code = 2'($urandom); op_rx = 3'($urandom); op_ry = 3'($urandom); op_imm = 8'($urandom);
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (!(q.size() == 0 && op_ready) && n < 100);
    if (n == 100) chk("idle_timeout", 64'd1, 64'd0);
  endtask
  initial begin
    for (int i = 0; i < 8; i++) begin bank[i] = 8'($urandom); model[i] = bank[i]; end
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(op_ready), 64'd1);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_strobes", {reg_read_en, reg_write_en}, 0);
    chk("rst_sels_wdata", {reg_rx_sel, reg_ry_sel, reg_wdata}, 0);
    rst_n = 1;
    issue(SWP, 3'd6, 3'd7, 8'h00, 0, 0);
    @(negedge clk);
    chk("swp_rdx_read", 64'(reg_read_en), 64'd1);
    rst_n = 0;
    #1;
    chk("midrst_strobes", {reg_read_en, reg_write_en, busy, done}, 0);
    chk("midrst_ready", 64'(op_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("postrst_quiet", {reg_read_en, reg_write_en, busy, done}, 0);
    issue(CLR, 3'd4, 3'd0, 8'h00, 1, 0);
    wait_idle();
    issue(LDI, 3'd4, 3'd0, 8'hAA, 1, 0);
    issue(MOV, 3'd0, 3'd4, 8'h00, 1, 0);
    wait_idle();
    chk("r0_is_aa", 64'(bank[0]), 64'hAA);
    issue(LDI, 3'd1, 3'd0, 8'h12, 1, 0);
    issue(LDI, 3'd2, 3'd0, 8'h34, 1, 0);
    issue(SWP, 3'd1, 3'd2, 8'h00, 1, 0);
    wait_idle();
    chk("swp_r1_r2", {bank[1], bank[2]}, 16'h3412);
    issue(LDI, 3'd3, 3'd0, 8'hFF, 1, 0);
    issue(CLR, 3'd3, 3'd0, 8'h00, 1, 0);
    wait_idle();
    chk("r3_cleared", 64'(bank[3]), 64'h00);
    issue(LDI, 3'd6, 3'd0, 8'hC3, 1, 1);
    b2b = 1;
    issue(MOV, 3'd7, 3'd6, 8'h00, 1, 1);
    issue(SWP, 3'd6, 3'd1, 8'h00, 1, 1);
    issue(CLR, 3'd2, 3'd0, 8'h00, 1, 0);
    wait_idle();
    b2b = 0;
    issue(LDI, 3'd5, 3'd0, 8'h5A, 1, 0);
    issue(SWP, 3'd5, 3'd5, 8'h00, 1, 0);
    wait_idle();
    chk("r5_unchanged", 64'(bank[5]), 64'h5A);
    for (int i = 0; i < 40; i++)
      issue(2'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 1, 1'($urandom));
    wait_idle();
    chk("final_regfile", snap_bank(), snap_model());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog");
  end
endmodule
